// File: rtl/afu_csr_pkg.sv
// afu_csr_pkg: CCI-P subset types, MMIO register map, CTRL bit positions,
// DFH constant and the control FSM state type shared by the CSR file.
package afu_csr_pkg;

    // ---------------- CCI-P subset ----------------
    typedef struct packed {
        logic [15:0] address;   // DWORD address
        logic [1:0]  length;    // 0: 4B, 1: 8B
        logic        rsvd;
        logic [8:0]  tid;
    } t_ccip_c0_ReqMmioHdr;

    typedef struct packed {
        t_ccip_c0_ReqMmioHdr hdr;
        logic [511:0]        data;
        logic                rspValid;
        logic                mmioRdValid;
        logic                mmioWrValid;
    } t_if_ccip_c0_Rx;

    typedef struct packed {
        logic           c0TxAlmFull;
        logic           c1TxAlmFull;
        t_if_ccip_c0_Rx c0;
    } t_if_ccip_Rx;

    typedef struct packed {
        logic [73:0] hdr;
        logic        valid;
    } t_if_ccip_c0_Tx;

    typedef struct packed {
        logic [79:0]  hdr;
        logic [511:0] data;
        logic         valid;
    } t_if_ccip_c1_Tx;

    typedef struct packed {
        logic [8:0] tid;
    } t_ccip_c2_RspMmioHdr;

    typedef struct packed {
        t_ccip_c2_RspMmioHdr hdr;
        logic                mmioRdValid;
        logic [63:0]         data;
    } t_if_ccip_c2_Tx;

    typedef struct packed {
        t_if_ccip_c0_Tx c0;
        t_if_ccip_c1_Tx c1;
        t_if_ccip_c2_Tx c2;
    } t_if_ccip_Tx;

    // ---------------- Register map (DWORD addresses) ----------------
    localparam logic [1:0]  MMIO_LEN_8B   = 2'd1;
    localparam logic [15:0] ADDR_DFH      = 16'h0000;
    localparam logic [15:0] ADDR_ID_L     = 16'h0002;
    localparam logic [15:0] ADDR_ID_H     = 16'h0004;
    localparam logic [15:0] ADDR_CTRL     = 16'h000A;
    localparam logic [15:0] ADDR_CYC_CNT  = 16'h000C;
    localparam logic [15:0] ADDR_BUSY_CNT = 16'h000E;
    localparam logic [15:0] ADDR_BUF_BASE = 16'h0010;

    // CTRL write / read bit positions
    localparam int CTRL_START = 0;
    localparam int CTRL_CLR   = 1;
    localparam int CTRL_BUSY  = 0;
    localparam int CTRL_DONE  = 1;
    localparam int CTRL_ERR   = 2;

    // DFH: feature type AFU (4'h1 in [63:60]), end-of-list (bit 40)
    localparam logic [63:0] AFU_DFH = 64'h1000_0100_0000_0000;

    typedef enum logic {
        CTRL_IDLE = 1'b0,
        CTRL_RUN  = 1'b1
    } t_ctrl_state;

    // DWORD address of BUF[i]
    function automatic logic [15:0] buf_reg_addr(input int unsigned i);
        return 16'(32'(ADDR_BUF_BASE) + 2 * i);
    endfunction

endpackage

// File: rtl/afu_csr_ctrl.sv
// afu_csr_ctrl: IDLE/RUN engine handshake with sticky DONE/ERR flags.
// With AFU_CSR_PERF_CNT_EN defined, also counts cycles spent busy.
module afu_csr_ctrl
    import afu_csr_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_wr,
    input  logic        clr_wr,
    input  logic        done,
    output logic        start,
    output logic        busy,
    output logic        done_flag,
    output logic        err_flag
`ifdef AFU_CSR_PERF_CNT_EN
    ,
    output logic [63:0] busy_cnt
`endif
);

    t_ctrl_state state_q, state_d;
    logic        launch;
    logic        done_d, err_d;

    // State register plus registered start pulse and sticky flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= CTRL_IDLE;
            start     <= 1'b0;
            done_flag <= 1'b0;
            err_flag  <= 1'b0;
        end else begin
            state_q   <= state_d;
            start     <= launch;
            done_flag <= done_d;
            err_flag  <= err_d;
        end
    end

    // Next state: START launches from IDLE, done returns from RUN
    always_comb begin
        state_d = state_q;
        case (state_q)
            CTRL_IDLE: if (start_wr) state_d = CTRL_RUN;
            CTRL_RUN:  if (done)     state_d = CTRL_IDLE;
            default:   state_d = CTRL_IDLE;
        endcase
    end

    // Outputs: CLR first, then START, and an engine done overrides CLR
    always_comb begin
        launch = 1'b0;
        done_d = done_flag;
        err_d  = err_flag;
        if (clr_wr) begin
            done_d = 1'b0;
            err_d  = 1'b0;
        end
        if (start_wr) begin
            if (state_q == CTRL_IDLE) begin
                launch = 1'b1;
                done_d = 1'b0;
            end else begin
                err_d = 1'b1;
            end
        end
        if (done && state_q == CTRL_RUN) done_d = 1'b1;
    end

    assign busy = (state_q == CTRL_RUN);

`ifdef AFU_CSR_PERF_CNT_EN
    // Busy-cycle counter, restarted by the START that enters RUN
    always_ff @(posedge clk) begin
        if (!rst_n)      busy_cnt <= '0;
        else if (launch) busy_cnt <= '0;
        else if (busy)   busy_cnt <= busy_cnt + 64'd1;
    end
`endif

endmodule

// File: rtl/afu_csr_file.sv
// afu_csr_file: CCI-P MMIO register file (DFH, ID, CTRL, BUF[] bank),
// sole driver of tx.c2. Define AFU_CSR_PERF_CNT_EN to add CYC_CNT/BUSY_CNT.
module afu_csr_file
    import afu_csr_pkg::*;
#(
    parameter int unsigned  NUM_BUF = 4,
    parameter logic [127:0] AFU_ID  = 128'h0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  t_if_ccip_Rx               rx,
    output t_if_ccip_Tx               tx,
    output logic [NUM_BUF-1:0][63:0]  buf_addr,
    output logic                      start,
    input  logic                      done,
    output logic                      busy
);

    t_ccip_c0_ReqMmioHdr hdr;
    logic                is_8b;
    logic                acc_ok;
    logic [15:0]         reg_addr;
    logic [63:0]         wr_data;
    logic                ctrl_wr, start_wr, clr_wr;
    logic                done_flag, err_flag;
    logic [63:0]         rd_reg, rd_data;
    t_if_ccip_c2_Tx      c2_q;
    logic [NUM_BUF-1:0][63:0] buf_q;

    assign hdr      = rx.c0.hdr;
    assign is_8b    = (hdr.length == MMIO_LEN_8B);
    assign acc_ok   = !(is_8b && hdr.address[0]);   // 8B must be QWORD aligned
    assign reg_addr = {hdr.address[15:1], 1'b0};
    assign wr_data  = rx.c0.data[63:0];

    // Only the low half of CTRL carries command bits
    assign ctrl_wr  = rx.c0.mmioWrValid && acc_ok && (hdr.address == ADDR_CTRL);
    assign start_wr = ctrl_wr && wr_data[CTRL_START];
    assign clr_wr   = ctrl_wr && wr_data[CTRL_CLR];

    logic unused_rx;
    assign unused_rx = ^{rx.c0TxAlmFull, rx.c1TxAlmFull, rx.c0.rspValid,
                         rx.c0.data[511:64], hdr.rsvd};

`ifdef AFU_CSR_PERF_CNT_EN
    logic [63:0] cyc_cnt, busy_cnt;

    // Free-running cycle counter
    always_ff @(posedge clk) begin
        if (!rst_n) cyc_cnt <= '0;
        else        cyc_cnt <= cyc_cnt + 64'd1;
    end
`endif

    afu_csr_ctrl u_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_wr  (start_wr),
        .clr_wr    (clr_wr),
        .done      (done),
        .start     (start),
        .busy      (busy),
        .done_flag (done_flag),
        .err_flag  (err_flag)
`ifdef AFU_CSR_PERF_CNT_EN
        ,
        .busy_cnt  (busy_cnt)
`endif
    );

    // BUF bank: 8B writes replace, 4B writes update the addressed half
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buf_q <= '0;
        end else if (rx.c0.mmioWrValid && acc_ok) begin
            for (int unsigned i = 0; i < NUM_BUF; i++) begin
                if (reg_addr == buf_reg_addr(i)) begin
                    if (is_8b)               buf_q[i]        <= wr_data;
                    else if (hdr.address[0]) buf_q[i][63:32] <= wr_data[31:0];
                    else                     buf_q[i][31:0]  <= wr_data[31:0];
                end
            end
        end
    end

    assign buf_addr = buf_q;

    // Read mux: full 64-bit register, then size/half selection
    always_comb begin
        rd_reg = '0;
        case (reg_addr)
            ADDR_DFH:      rd_reg = AFU_DFH;
            ADDR_ID_L:     rd_reg = AFU_ID[63:0];
            ADDR_ID_H:     rd_reg = AFU_ID[127:64];
            ADDR_CTRL:     rd_reg = {61'b0, err_flag, done_flag, busy};
`ifdef AFU_CSR_PERF_CNT_EN
            ADDR_CYC_CNT:  rd_reg = cyc_cnt;
            ADDR_BUSY_CNT: rd_reg = busy_cnt;
`endif
            default:       rd_reg = '0;
        endcase
        for (int unsigned i = 0; i < NUM_BUF; i++) begin
            if (reg_addr == buf_reg_addr(i)) rd_reg = buf_q[i];
        end
        if (!acc_ok)             rd_data = '0;
        else if (is_8b)          rd_data = rd_reg;
        else if (hdr.address[0]) rd_data = {32'b0, rd_reg[63:32]};
        else                     rd_data = {32'b0, rd_reg[31:0]};
    end

    // c2 response register: one cycle read latency, no stall
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            c2_q <= '0;
        end else begin
            c2_q.mmioRdValid <= rx.c0.mmioRdValid;
            c2_q.hdr.tid     <= hdr.tid;
            c2_q.data        <= rd_data;
        end
    end

    assign tx = '{c0: '0, c1: '0, c2: c2_q};

endmodule
